// File: rtl/comparator_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM encoding and counter sizing.
package comparator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Slice-index counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/slice_compare.sv
// Combinational SLICE-bit unsigned compare: per-bit XNOR equality plus MSB-first magnitude chain.
module slice_compare #(
  parameter int unsigned SLICE = 2
) (
  input  logic [SLICE-1:0] sa,
  input  logic [SLICE-1:0] sb,
  output logic             s_eq,
  output logic             s_gt
);

  logic [SLICE-1:0] bit_eq;

  assign bit_eq = ~(sa ^ sb);

  always_comb begin
    logic higher_eq;
    higher_eq = 1'b1;
    s_gt      = 1'b0;
    // The first differing bit from the top decides the magnitude.
    for (int i = SLICE - 1; i >= 0; i--) begin
      s_gt      = s_gt | (higher_eq & sa[i] & ~sb[i]);
      higher_eq = higher_eq & bit_eq[i];
    end
    s_eq = higher_eq;
  end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Slice-serial MSB-first magnitude comparator with early exit and start/busy/done handshake.
// Define SERIAL_CMP_SIGNED_EN to compare operands as two's complement.
module serial_magnitude_comparator
  import comparator_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SLICE = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic [WIDTH-1:0] eq_mask
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned IDX_W  = cnt_width(NSLICE);

  state_e             state_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [IDX_W-1:0]   idx_q;
  logic               busy_q, done_q, eq_q, gt_q, lt_q;
  logic [WIDTH-1:0]   mask_q;

  logic [SLICE-1:0]   sa, sb;
  logic               s_eq, s_gt;

  always_comb begin
    sa = a_q[idx_q * SLICE +: SLICE];
    sb = b_q[idx_q * SLICE +: SLICE];
`ifdef SERIAL_CMP_SIGNED_EN
    // Flipping the sign bits maps two's complement order onto unsigned order.
    if (idx_q == IDX_W'(NSLICE - 1)) begin
      sa[SLICE-1] = ~sa[SLICE-1];
      sb[SLICE-1] = ~sb[SLICE-1];
    end
`endif
  end

  slice_compare #(
    .SLICE(SLICE)
  ) u_slice_compare (
    .sa  (sa),
    .sb  (sb),
    .s_eq(s_eq),
    .s_gt(s_gt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      mask_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            idx_q   <= IDX_W'(NSLICE - 1);
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            mask_q  <= ~(a ^ b);
            busy_q  <= 1'b1;
            state_q <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (!s_eq) begin
            gt_q    <= s_gt;
            lt_q    <= ~s_gt;
            busy_q  <= 1'b0;
            state_q <= ST_DONE;
          end else if (idx_q == '0) begin
            eq_q    <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_DONE;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign eq      = eq_q;
  assign gt      = gt_q;
  assign lt      = lt_q;
  assign eq_mask = mask_q;

endmodule
